// File: rtl/y86_decode.sv
`default_nettype none
// ============================================================================
// y86_decode : Y86-64 decode/write-back stage with 15-entry register file
// Revision   : 1.0
// ============================================================================
module y86_decode #(
  parameter int         DATA_W = 64,
  parameter logic [3:0] RSP_ID = 4'h4,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic              wb_en,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB
);

  localparam int NREGS = 15;

  logic [DATA_W-1:0] regs_q [0:NREGS-1];
  logic [DATA_W-1:0] regs_d [0:NREGS-1];

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      4'h2: begin
        srcA = rA;
        dstE = cnd ? rB : RNONE;
      end
      4'h3: dstE = rB;
      4'h4: begin
        srcA = rA;
        srcB = rB;
      end
      4'h5: begin
        srcB = rB;
        dstM = rA;
      end
      4'h6: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      4'h8: begin
        srcB = RSP_ID;
        dstE = RSP_ID;
      end
      4'h9: begin
        srcA = RSP_ID;
        srcB = RSP_ID;
        dstE = RSP_ID;
      end
      4'hA: begin
        srcA = rA;
        srcB = RSP_ID;
        dstE = RSP_ID;
      end
      4'hB: begin
        srcA = RSP_ID;
        srcB = RSP_ID;
        dstE = RSP_ID;
        dstM = rA;
      end
      default: ;
    endcase
  end

  // M-port update is applied after E-port so valM wins on a shared destination.
  always_comb begin
    regs_d = regs_q;
    if (wb_en) begin
      for (int i = 0; i < NREGS; i++) begin
        if (dstE != RNONE && dstE == 4'(i)) regs_d[i] = valE;
        if (dstM != RNONE && dstM == 4'(i)) regs_d[i] = valM;
      end
    end
  end

  // Reads see only the stored state; a same-cycle write is not bypassed.
  always_comb begin
    valA = '0;
    valB = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (srcA != RNONE && srcA == 4'(i)) valA = regs_q[i];
      if (srcB != RNONE && srcB == 4'(i)) valB = regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y86_decode.sv
`default_nettype none
// ============================================================================
// tb_y86_decode : table-driven ID checks plus write-back/reset sequences
// Revision      : 1.0
// ============================================================================
module tb_y86_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  icode, rA, rB;
  logic        cnd, wb_en;
  logic [63:0] valE, valM;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] ic, ra, rb;
    logic       c;
    logic [3:0] sa, sb, de, dm;
  } vec_t;

  typedef struct {
    string       nm;
    logic [3:0]  sa, sb, de, dm;
    logic [63:0] va, vb;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[0:23];

  y86_decode #(.DATA_W(64), .RSP_ID(4'h4), .RNONE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
    .wb_en(wb_en), .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
    .dstE(dstE), .dstM(dstM), .valA(valA), .valB(valB)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic we, input logic [63:0] ve, input logic [63:0] vm);
    icode = ic; rA = ra; rB = rb; cnd = c; wb_en = we; valE = ve; valM = vm;
  endtask

  task automatic expect_out(input string nm, input logic [3:0] sa, input logic [3:0] sbv,
                            input logic [3:0] de, input logic [3:0] dm,
                            input logic [63:0] va, input logic [63:0] vb);
    exp_t e;
    e.nm = nm; e.sa = sa; e.sb = sbv; e.de = de; e.dm = dm; e.va = va; e.vb = vb;
    sb_q.push_back(e);
  endtask

  // Sample 1 time unit after driving, well away from the rising edge.
  task automatic check_pop();
    exp_t e;
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      if ({srcA, srcB, dstE, dstM, valA, valB} !== {e.sa, e.sb, e.de, e.dm, e.va, e.vb}) begin
        errors++;
        $display("FAIL %s: got srcA=%h srcB=%h dstE=%h dstM=%h valA=%h valB=%h, want srcA=%h srcB=%h dstE=%h dstM=%h valA=%h valB=%h",
                 e.nm, srcA, srcB, dstE, dstM, valA, valB, e.sa, e.sb, e.de, e.dm, e.va, e.vb);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{4'h2, 4'h2, 4'h2, 1'b0, 4'h2, 4'hF, 4'hF, 4'hF};
    vecs[1]  = '{4'h2, 4'h2, 4'h2, 1'b1, 4'h2, 4'hF, 4'h2, 4'hF};
    vecs[2]  = '{4'h3, 4'h0, 4'h8, 1'b0, 4'hF, 4'hF, 4'h8, 4'hF};
    vecs[3]  = '{4'h3, 4'h0, 4'h8, 1'b1, 4'hF, 4'hF, 4'h8, 4'hF};
    vecs[4]  = '{4'h4, 4'hC, 4'h5, 1'b0, 4'hC, 4'h5, 4'hF, 4'hF};
    vecs[5]  = '{4'h4, 4'hC, 4'h5, 1'b1, 4'hC, 4'h5, 4'hF, 4'hF};
    vecs[6]  = '{4'h5, 4'hE, 4'h9, 1'b0, 4'hF, 4'h9, 4'hF, 4'hE};
    vecs[7]  = '{4'h5, 4'hE, 4'h9, 1'b1, 4'hF, 4'h9, 4'hF, 4'hE};
    vecs[8]  = '{4'h6, 4'h3, 4'h1, 1'b0, 4'h3, 4'h1, 4'h1, 4'hF};
    vecs[9]  = '{4'h6, 4'h3, 4'h1, 1'b1, 4'h3, 4'h1, 4'h1, 4'hF};
    vecs[10] = '{4'h8, 4'h0, 4'hE, 1'b0, 4'hF, 4'h4, 4'h4, 4'hF};
    vecs[11] = '{4'h8, 4'h0, 4'hE, 1'b1, 4'hF, 4'h4, 4'h4, 4'hF};
    vecs[12] = '{4'h9, 4'h7, 4'h6, 1'b0, 4'h4, 4'h4, 4'h4, 4'hF};
    vecs[13] = '{4'h9, 4'h7, 4'h6, 1'b1, 4'h4, 4'h4, 4'h4, 4'hF};
    vecs[14] = '{4'hA, 4'h5, 4'h0, 1'b0, 4'h5, 4'h4, 4'h4, 4'hF};
    vecs[15] = '{4'hA, 4'h5, 4'h0, 1'b1, 4'h5, 4'h4, 4'h4, 4'hF};
    vecs[16] = '{4'hB, 4'h0, 4'h0, 1'b0, 4'h4, 4'h4, 4'h4, 4'h0};
    vecs[17] = '{4'hB, 4'h0, 4'h0, 1'b1, 4'h4, 4'h4, 4'h4, 4'h0};
    vecs[18] = '{4'h0, 4'h3, 4'h5, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
    vecs[19] = '{4'h1, 4'h6, 4'h7, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF};
    vecs[20] = '{4'h7, 4'h2, 4'h3, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
    vecs[21] = '{4'hC, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
    vecs[22] = '{4'hE, 4'h4, 4'h4, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
    vecs[23] = '{4'hF, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};

    rst_n = 1'b0;
    drive(4'h9, 4'h0, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    #2;
    expect_out("reset_read", 4'h4, 4'h4, 4'h4, 4'hF, 64'h0, 64'h0);
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ID table: registers all hold zero, so every read expects 0.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(vecs[i].ic, vecs[i].ra, vecs[i].rb, vecs[i].c, 1'b0, 64'hDEAD, 64'hBEEF);
      expect_out($sformatf("ids_vec%0d", i), vecs[i].sa, vecs[i].sb, vecs[i].de, vecs[i].dm,
                 64'h0, 64'h0);
      check_pop();
    end

    // irmovq into r2, then read through cmov srcA.
    @(negedge clk);
    drive(4'h3, 4'hF, 4'h2, 1'b0, 1'b1, 64'h1234, 64'h0);
    @(negedge clk);
    drive(4'h2, 4'h2, 4'h2, 1'b0, 1'b0, 64'h0, 64'h0);
    expect_out("irmovq_wb", 4'h2, 4'hF, 4'hF, 4'hF, 64'h1234, 64'h0);
    check_pop();

    // Same-cycle write to r2 must not be visible before the edge.
    @(negedge clk);
    drive(4'h6, 4'h2, 4'h2, 1'b0, 1'b1, 64'h7777, 64'h0);
    expect_out("no_bypass", 4'h2, 4'h2, 4'h2, 4'hF, 64'h1234, 64'h1234);
    check_pop();
    @(negedge clk);
    drive(4'h6, 4'h2, 4'h2, 1'b0, 1'b0, 64'h0, 64'h0);
    expect_out("opq_wb", 4'h2, 4'h2, 4'h2, 4'hF, 64'h7777, 64'h7777);
    check_pop();

    // wb_en=0 leaves r3 untouched.
    @(negedge clk);
    drive(4'h3, 4'hF, 4'h3, 1'b0, 1'b0, 64'h5555, 64'h0);
    @(negedge clk);
    drive(4'h2, 4'h3, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    expect_out("wb_disabled", 4'h3, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0);
    check_pop();

    // cmov with cnd=0 writes nothing even with wb_en=1.
    @(negedge clk);
    drive(4'h2, 4'h0, 4'h6, 1'b0, 1'b1, 64'hAAAA, 64'h0);
    @(negedge clk);
    drive(4'h6, 4'h6, 4'h6, 1'b0, 1'b0, 64'h0, 64'h0);
    expect_out("cmov_not_taken", 4'h6, 4'h6, 4'h6, 4'hF, 64'h0, 64'h0);
    check_pop();

    // popq rA=5: r4 <- valE, r5 <- valM.
    @(negedge clk);
    drive(4'hB, 4'h5, 4'h0, 1'b0, 1'b1, 64'h20, 64'h55);
    @(negedge clk);
    drive(4'h6, 4'h4, 4'h5, 1'b0, 1'b0, 64'h0, 64'h0);
    expect_out("popq_split", 4'h4, 4'h5, 4'h5, 4'hF, 64'h20, 64'h55);
    check_pop();

    // popq rA=4: valM beats valE on the shared destination.
    @(negedge clk);
    drive(4'hB, 4'h4, 4'h0, 1'b0, 1'b1, 64'h10, 64'h99);
    @(negedge clk);
    drive(4'h9, 4'h0, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    expect_out("popq_priority", 4'h4, 4'h4, 4'h4, 4'hF, 64'h99, 64'h99);
    check_pop();

    // Undefined icode with wb_en=1 must not disturb r4.
    @(negedge clk);
    drive(4'hF, 4'h4, 4'h4, 1'b1, 1'b1, 64'h1111, 64'h2222);
    @(negedge clk);
    drive(4'h9, 4'h0, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    expect_out("undef_no_write", 4'h4, 4'h4, 4'h4, 4'hF, 64'h99, 64'h99);
    check_pop();

    // Asynchronous reset between edges clears reads at once.
    #1;
    rst_n = 1'b0;
    expect_out("async_reset", 4'h4, 4'h4, 4'h4, 4'hF, 64'h0, 64'h0);
    check_pop();

    // Write edge while in reset is ignored.
    drive(4'h3, 4'h0, 4'h2, 1'b0, 1'b1, 64'hABC, 64'h0);
    @(negedge clk);
    drive(4'h6, 4'h2, 4'h4, 1'b0, 1'b0, 64'h0, 64'h0);
    expect_out("write_in_reset", 4'h2, 4'h4, 4'h4, 4'hF, 64'h0, 64'h0);
    check_pop();

    // After release, writes work again.
    rst_n = 1'b1;
    @(negedge clk);
    drive(4'h3, 4'h0, 4'hE, 1'b0, 1'b1, 64'hCAFE, 64'h0);
    @(negedge clk);
    drive(4'h4, 4'hE, 4'h2, 1'b0, 1'b0, 64'h0, 64'h0);
    expect_out("post_reset_wb", 4'hE, 4'h2, 4'hF, 4'hF, 64'hCAFE, 64'h0);
    check_pop();

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running want finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/y86_decode.md
Name: y86_decode

Overview:
- Decode/write-back block of the sequential Y86-64 processor.
- Combinationally maps icode/rA/rB/cnd to register IDs srcA, srcB, dstE and dstM.
- Holds the 15-entry program register file. Reads valA/valB combinationally and writes valE/valM back on the clock edge.
- Sits between the fetch stage (icode, rA, rB), the execute stage (cnd, valE) and the memory stage (valM).

Parameters:
- DATA_W, 64, register and data word width.
- RSP_ID, 4'h4, register ID of %rsp.
- RNONE, 4'hF, "no register" ID.

Ports:
- clk  in  1  single clock; all register-file writes happen on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- icode  in  4  instruction code from fetch.
- rA  in  4  register specifier A.
- rB  in  4  register specifier B.
- cnd  in  1  condition result from execute; used by cmovXX.
- wb_en  in  1  write-back enable for the current instruction.
- valE  in  DATA_W  execute result, written to dstE.
- valM  in  DATA_W  memory result, written to dstM.
- srcA  out  4  read register ID A.
- srcB  out  4  read register ID B.
- dstE  out  4  E-port destination ID.
- dstM  out  4  M-port destination ID.
- valA  out  DATA_W  register-file value at srcA.
- valB  out  DATA_W  register-file value at srcB.

Behaviour:

ID generation (purely combinational, no latency):
- srcA:
  - rA for icode 2 (cmovXX), 4 (rmmovq), 6 (OPq), A (pushq).
  - RSP_ID for icode 9 (ret), B (popq).
  - RNONE otherwise.
- srcB:
  - rB for icode 4, 5 (mrmovq), 6.
  - RSP_ID for icode 8 (call), 9, A, B.
  - RNONE otherwise.
- dstE:
  - icode 2: rB when cnd=1, else RNONE.
  - rB for icode 3 (irmovq), 6.
  - RSP_ID for icode 8, 9, A, B.
  - RNONE otherwise.
- dstM: rA for icode 5, B; RNONE otherwise.
- icode 0, 1, 7 and undefined codes C–F: all four IDs = RNONE.
- cnd affects only dstE, and only when icode=2.

Register file:
- 15 registers, IDs 0–14.
- valA = reg[srcA] and valB = reg[srcB], combinational.
- ID RNONE reads 0.
- A read in the same cycle as a write to that register returns the old value; there is no internal bypass.

Write-back (rising clk, when wb_en=1):
- reg[dstE] <= valE if dstE != RNONE.
- reg[dstM] <= valM if dstM != RNONE.
- If dstE == dstM (not RNONE), valM wins.
- wb_en=0: no register changes.

Reset:
- rst_n=0 asynchronously clears all 15 registers to 0, regardless of clk.
- srcA/srcB/dstE/dstM stay combinational functions of their inputs during reset.
- valA/valB read 0 during and immediately after reset.
- A write edge coincident with asserted reset is ignored.
- Deassertion takes effect at the next clk edge.

Test Plan:
1. icode=2, rA=2, rB=2, toggle cnd 0→1 -> srcA=2, srcB=F, dstM=F; dstE=F with cnd=0, dstE=2 with cnd=1.
2. Per-icode ID checks, cnd toggled for each:
   - icode=3, rA=0, rB=8 -> srcA=F, srcB=F, dstE=8, dstM=F.
   - icode=4, rA=C, rB=5 -> srcA=C, srcB=5, dstE=F, dstM=F.
   - icode=5, rA=E, rB=9 -> srcA=F, srcB=9, dstE=F, dstM=E.
   - icode=6, rA=3, rB=1 -> srcA=3, srcB=1, dstE=1, dstM=F.
3. Stack instructions:
   - icode=8, rB=E -> srcA=F, srcB=4, dstE=4.
   - icode=9 -> srcA=4, srcB=4, dstE=4.
   - icode=A, rA=5 -> srcA=5, srcB=4, dstE=4.
   - icode=B, rA=0 -> srcA=4, srcB=4, dstE=4, dstM=0.
4. Write-back:
   - After reset, irmovq (icode=3, rB=2, valE=0x1234, wb_en=1), one clk -> then srcA=2 via icode=2, rA=2 reads valA=0x1234.
   - Same stimulus with wb_en=0 -> valA stays 0.
5. Priority and reset:
   - popq with rA=4 (dstE=dstM=4), valE=0x10, valM=0x99 -> reg4=0x99.
   - Then assert rst_n=0 between clk edges -> valB (srcB=4) drops to 0 immediately.
6. icode=0, 1, 7, F with any rA/rB/cnd -> all IDs F, valA=valB=0, no write on clk.
